systolic_skew_feeder: RTL

- Edge feeder placed directly upstream of one row or column of PE cells in the systolic array.
- Accepts one LANES-wide vector of signed INT8 operands per cycle over a valid/ready handshake.
- Skews the vector diagonally: lane i is delayed i cycles more than lane 0. Each lane drives the OPNDx_in / OPNDx_is_valid_in pair of the first PE in that row/column.
- Frames a stream with a last marker and signals DONE when the final skewed element leaves the highest lane.

---
 rtl/systolic_skew_feeder_if.sv | 26 ++
 rtl/systolic_skew_feeder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder_if.sv
// Operand stream into the skew feeder and the skewed operand/valid pairs
// it drives onto the first PE of each row/column.
interface systolic_skew_feeder_if #(
    parameter int OPND_BWIDTH = 8,
    parameter int LANES       = 4
);
    logic                         IN_VALID;
    logic                         IN_READY;
    logic [LANES*OPND_BWIDTH-1:0] IN_DATA;
    logic                         IN_LAST;
    logic [LANES*OPND_BWIDTH-1:0] OPND_out;
    logic [LANES-1:0]             OPND_is_valid_out;

    // Handshake: a vector moves on a rising CLK edge where IN_VALID and
    // IN_READY are both high; IN_DATA/IN_LAST must be stable while IN_VALID
    // is high, and IN_READY never depends on IN_VALID.
    modport master (
        output IN_VALID, IN_DATA, IN_LAST,
        input  IN_READY, OPND_out, OPND_is_valid_out
    );

    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST,
        output IN_READY, OPND_out, OPND_is_valid_out
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for one edge of a systolic array: lane i delays its
// operand i cycles more than lane 0, and DONE flags the final skewed element.
module systolic_skew_feeder #(
    parameter int OPND_BWIDTH = 8,
    parameter int LANES       = 4,
    parameter int CNT_BWIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  STALL,
    systolic_skew_feeder_if.slave bus,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [CNT_BWIDTH-1:0] VEC_CNT,
    output logic [1:0]            STATE_DBG
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic                         accepting;
    logic                         in_ready;
    logic                         transfer;
    logic                         done;
    logic [CNT_BWIDTH-1:0]        cnt_q, cnt_d;
    logic [LANES-1:0]             tag_q;
    logic [LANES*OPND_BWIDTH-1:0] opnd_flat;
    logic [LANES-1:0]             vld_flat;

    // Ready is forced low while reset is asserted, not only after it.
    assign in_ready     = RSTn & ~STALL & accepting;
    assign transfer     = bus.IN_VALID & in_ready;
    assign bus.IN_READY = in_ready;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!STALL) begin
            unique case (state_q)
                IDLE:    if (transfer) state_d = bus.IN_LAST ? DRAIN : STREAM;
                STREAM:  if (transfer && bus.IN_LAST) state_d = DRAIN;
                DRAIN:   if (done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        accepting = (state_q == IDLE) || (state_q == STREAM);
        BUSY      = (state_q != IDLE);
        STATE_DBG = state_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!STALL) begin
            if (state_q == DRAIN && done) begin
                cnt_d = '0;
            end else if (transfer) begin
                cnt_d = cnt_q + CNT_BWIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign VEC_CNT = cnt_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [OPND_BWIDTH-1:0] d_q [i+1];
        logic                   v_q [i+1];

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                for (int j = 0; j <= i; j++) begin
                    d_q[j] <= '0;
                    v_q[j] <= 1'b0;
                end
            end else if (!STALL) begin
                d_q[0] <= transfer ? bus.IN_DATA[i*OPND_BWIDTH +: OPND_BWIDTH] : '0;
                v_q[0] <= transfer;
                for (int j = 1; j <= i; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign opnd_flat[i*OPND_BWIDTH +: OPND_BWIDTH] = d_q[i];
        assign vld_flat[i]                             = v_q[i];
    end

    // The last tag rides alongside the highest lane only.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tag_q <= '0;
        end else if (!STALL) begin
            tag_q[0] <= transfer & bus.IN_LAST;
            for (int j = 1; j < LANES; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    assign done                  = tag_q[LANES-1] & vld_flat[LANES-1];
    assign DONE                  = done;
    assign bus.OPND_out          = opnd_flat;
    assign bus.OPND_is_valid_out = vld_flat;

endmodule
